// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared cache types: bypass request/response, ACE transaction kinds, bypass FSM.
package std_cache_pkg;

    localparam int unsigned BypassAddrW = 64;
    localparam int unsigned BypassDataW = 64;
    localparam int unsigned BypassIdW   = 4;

    typedef enum logic [3:0] {
        READ_NO_SNOOP  = 4'd0,
        READ_ONCE      = 4'd1,
        READ_SHARED    = 4'd2,
        READ_UNIQUE    = 4'd3,
        CLEAN_UNIQUE   = 4'd4,
        WRITE_NO_SNOOP = 4'd5,
        WRITE_UNIQUE   = 4'd6,
        WRITE_BACK     = 4'd7
    } ace_trs_t;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_LR   = 4'd1,
        AMO_SC   = 4'd2,
        AMO_SWAP = 4'd3,
        AMO_ADD  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_XOR  = 4'd7
    } amo_t;

    typedef struct packed {
        logic                     req;
        logic [1:0]               reqtype;
        ace_trs_t                 acetype;
        amo_t                     amo;
        logic [BypassIdW-1:0]     id;
        logic [BypassAddrW-1:0]   addr;
        logic [BypassDataW-1:0]   wdata;
        logic                     we;
        logic [BypassDataW/8-1:0] be;
        logic [1:0]               size;
    } bypass_req_t;

    typedef struct packed {
        logic                   gnt;
        logic                   valid;
        logic [BypassDataW-1:0] rdata;
    } bypass_rsp_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        RESP
    } bypass_fsm_t;

    // Returns {arsnoop[3:0], awsnoop[2:0], domain[1:0]}; a type that disagrees with we falls to NoSnoop.
    function automatic logic [8:0] ace_snoop_enc(input ace_trs_t trs, input logic we);
        logic [3:0] ar_snoop;
        logic [2:0] aw_snoop;
        logic [1:0] domain;
        ar_snoop = 4'b0000;
        aw_snoop = 3'b000;
        domain   = 2'b00;
        if (!we) begin
            case (trs)
                READ_ONCE:    domain = 2'b01;
                READ_SHARED:  begin ar_snoop = 4'b0001; domain = 2'b01; end
                READ_UNIQUE:  begin ar_snoop = 4'b0111; domain = 2'b01; end
                CLEAN_UNIQUE: begin ar_snoop = 4'b1011; domain = 2'b01; end
                default:      ;
            endcase
        end else begin
            case (trs)
                WRITE_UNIQUE: domain = 2'b01;
                WRITE_BACK:   aw_snoop = 3'b011;
                default:      ;
            endcase
        end
        return {ar_snoop, aw_snoop, domain};
    endfunction

endpackage

// File: rtl/std_bypass_responder.sv
// rtl/std_bypass_responder.sv - single-outstanding dcache bypass to single-beat ACE bridge.
// Optional response-code checking is enabled by defining STD_BYPASS_RESP_CHECK_EN.
module std_bypass_responder
    import std_cache_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  bypass_req_t            bypass_req_i,
    output bypass_rsp_t            bypass_rsp_o,
    output logic                   ar_valid_o,
    input  logic                   ar_ready_i,
    output logic [AddrWidth-1:0]   ar_addr_o,
    output logic [2:0]             ar_size_o,
    output logic [IdWidth-1:0]     ar_id_o,
    output logic [3:0]             ar_snoop_o,
    output logic [1:0]             ar_domain_o,
    input  logic                   r_valid_i,
    output logic                   r_ready_o,
    input  logic [DataWidth-1:0]   r_data_i,
    input  logic [3:0]             r_resp_i,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [AddrWidth-1:0]   aw_addr_o,
    output logic [2:0]             aw_size_o,
    output logic [IdWidth-1:0]     aw_id_o,
    output logic [2:0]             aw_snoop_o,
    output logic [1:0]             aw_domain_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [DataWidth-1:0]   w_data_o,
    output logic [DataWidth/8-1:0] w_strb_o,
    output logic                   w_last_o,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    input  logic [1:0]             b_resp_i,
    output logic                   err_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    bypass_fsm_t            state_q;
    bypass_req_t            req_q;
    logic [BypassDataW-1:0] rdata_q;
    logic                   valid_q, err_q;
    logic                   ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
    logic                   aw_done_q, w_done_q;

    logic       gnt;
    logic       aw_hs, w_hs;
    logic       r_err_d, b_err_d;
    logic [8:0] snoop_enc;

    assign gnt   = bypass_req_i.req && (state_q == IDLE) && rst_ni;
    assign aw_hs = aw_valid_q && aw_ready_i;
    assign w_hs  = w_valid_q && w_ready_i;

`ifdef STD_BYPASS_RESP_CHECK_EN
    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    assign r_err_d = r_resp_i[1];
    assign b_err_d = b_resp_i[1];
`else
    assign r_err_d = 1'b0;
    assign b_err_d = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (gnt) begin
                    req_q <= bypass_req_i;
                    if (bypass_req_i.amo != AMO_NONE) begin
                        rdata_q <= {BypassDataW{1'b1}};
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else if (!bypass_req_i.we) begin
                        rdata_q    <= '0;
                        ar_valid_q <= 1'b1;
                        state_q    <= RD_ADDR;
                    end else begin
                        rdata_q    <= '0;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        state_q    <= WR_ADDR_DATA;
                    end
                end
                RD_ADDR: if (ar_ready_i) begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b1;
                    state_q    <= RD_DATA;
                end
                RD_DATA: if (r_valid_i) begin
                    r_ready_q <= 1'b0;
                    rdata_q   <= r_err_d ? {BypassDataW{1'b1}} : BypassDataW'(r_data_i);
                    err_q     <= r_err_d;
                    valid_q   <= 1'b1;
                    state_q   <= RESP;
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done_q  <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end
                WR_RESP: if (b_valid_i) begin
                    b_ready_q <= 1'b0;
                    rdata_q   <= b_err_d ? {BypassDataW{1'b1}} : '0;
                    err_q     <= b_err_d;
                    valid_q   <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign snoop_enc = ace_snoop_enc(req_q.acetype, req_q.we);

    assign bypass_rsp_o.gnt   = gnt;
    assign bypass_rsp_o.valid = valid_q;
    assign bypass_rsp_o.rdata = rdata_q;

    assign ar_valid_o  = ar_valid_q;
    assign ar_addr_o   = AddrWidth'(req_q.addr);
    assign ar_size_o   = {1'b0, req_q.size};
    assign ar_id_o     = IdWidth'(req_q.id);
    assign ar_snoop_o  = snoop_enc[8:5];
    assign ar_domain_o = snoop_enc[1:0];
    assign r_ready_o   = r_ready_q;

    assign aw_valid_o  = aw_valid_q;
    assign aw_addr_o   = AddrWidth'(req_q.addr);
    assign aw_size_o   = {1'b0, req_q.size};
    assign aw_id_o     = IdWidth'(req_q.id);
    assign aw_snoop_o  = snoop_enc[4:2];
    assign aw_domain_o = snoop_enc[1:0];
    assign w_valid_o   = w_valid_q;
    assign w_data_o    = DataWidth'(req_q.wdata);
    assign w_strb_o    = StrbWidth'(req_q.be);
    assign w_last_o    = 1'b1;
    assign b_ready_o   = b_ready_q;

    assign err_o = err_q;

    logic unused_ok;
    assign unused_ok = ^{req_q.req, req_q.reqtype, req_q.amo, r_resp_i, b_resp_i};

endmodule

// File: tb/tb_std_bypass_responder.sv
// tb/tb_std_bypass_responder.sv - randomized scoreboard bench for std_bypass_responder.
module tb_std_bypass_responder;
    import std_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    bypass_req_t req_i = '0;
    bypass_rsp_t rsp_o;
    logic        ar_valid_o, ar_ready_i = 1'b0;
    logic [63:0] ar_addr_o;
    logic [2:0]  ar_size_o;
    logic [3:0]  ar_id_o, ar_snoop_o;
    logic [1:0]  ar_domain_o;
    logic        r_valid_i = 1'b0, r_ready_o;
    logic [63:0] r_data_i = '0;
    logic [3:0]  r_resp_i = '0;
    logic        aw_valid_o, aw_ready_i = 1'b0;
    logic [63:0] aw_addr_o;
    logic [2:0]  aw_size_o;
    logic [3:0]  aw_id_o;
    logic [2:0]  aw_snoop_o;
    logic [1:0]  aw_domain_o;
    logic        w_valid_o, w_ready_i = 1'b0;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o;
    logic        b_valid_i = 1'b0, b_ready_o;
    logic [1:0]  b_resp_i = '0;
    logic        err_o;

    std_bypass_responder dut (
        .clk_i(clk), .rst_ni(rst_ni), .bypass_req_i(req_i), .bypass_rsp_o(rsp_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_size_o(ar_size_o), .ar_id_o(ar_id_o), .ar_snoop_o(ar_snoop_o),
        .ar_domain_o(ar_domain_o), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i), .aw_valid_o(aw_valid_o),
        .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_size_o(aw_size_o),
        .aw_id_o(aw_id_o), .aw_snoop_o(aw_snoop_o), .aw_domain_o(aw_domain_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o), .b_valid_i(b_valid_i),
        .b_ready_o(b_ready_o), .b_resp_i(b_resp_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    int   outstanding = 0;

`ifdef STD_BYPASS_RESP_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    // ACE encodings indexed by transaction kind, as listed for the bypass port.
    logic [3:0] ars_tab [8] = '{4'd0, 4'd0, 4'd1, 4'd7, 4'd11, 4'd0, 4'd0, 4'd0};
    logic [2:0] aws_tab [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
    logic [1:0] dom_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0};

    int gnt_cyc, ar_cyc, resp_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_enc(input bypass_req_t r, output logic [3:0] ars,
                                    output logic [2:0] aws, output logic [1:0] dom);
        bit is_rd;
        int idx;
        idx   = int'(r.acetype);
        is_rd = (idx <= 4);
        if (is_rd == !r.we) begin
            ars = ars_tab[idx];
            aws = aws_tab[idx];
            dom = dom_tab[idx];
        end else begin
            ars = 4'd0;
            aws = 3'd0;
            dom = 2'd0;
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_o.gnt) begin
                chk("gnt_while_busy", 64'(outstanding), 64'd0);
                outstanding++;
            end
            if (rsp_o.valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_without_request", 64'(rsp_o.valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_o.rdata, e.rdata);
                    chk("rsp_err", 64'(err_o), 64'(e.err));
                end
                if (outstanding > 0) outstanding--;
            end else if (err_o) begin
                chk("err_outside_valid", 64'(err_o), 64'd0);
            end
        end
    end

    task automatic do_txn(input bypass_req_t r, input bypass_req_t nxt, input bit hold,
                          input logic [63:0] rd, input logic [1:0] rresp, input logic [1:0] bresp,
                          input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                          input int b_dly);
        logic [3:0] ars;
        logic [2:0] aws;
        logic [1:0] dom;
        exp_t       e;
        bit         got, bad, aw_acc, w_acc;
        int         k;
        ref_enc(r, ars, aws, dom);
        @(posedge clk); #1;
        req_i = r;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk); #1;
            if (rsp_o.gnt) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("gnt_seen", 64'(got), 64'd1);
        if (!got) begin req_i = '0; return; end
        gnt_cyc = cyc;
        if (r.amo != AMO_NONE) begin
            e.rdata = '1; e.err = 1'b0;
        end else if (!r.we) begin
            bad = CheckEn && rresp[1];
            e.rdata = bad ? '1 : rd; e.err = bad;
        end else begin
            bad = CheckEn && bresp[1];
            e.rdata = bad ? '1 : 64'd0; e.err = bad;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_i = hold ? nxt : '0;
        if (r.amo != AMO_NONE) begin
            @(negedge clk); #1;
            chk("amo_no_ar", 64'(ar_valid_o), 64'd0);
            chk("amo_no_aw", 64'(aw_valid_o), 64'd0);
        end else if (!r.we) begin
            k = 0; got = 0;
            while (!got) begin
                ar_ready_i = (k >= ar_dly);
                @(negedge clk); #1;
                chk("ar_valid_hold", 64'(ar_valid_o), 64'd1);
                if (k == 0) ar_cyc = cyc;
                if (ar_ready_i) begin
                    got = 1;
                    chk("ar_addr", ar_addr_o, r.addr);
                    chk("ar_size", 64'(ar_size_o), 64'({1'b0, r.size}));
                    chk("ar_id", 64'(ar_id_o), 64'(r.id));
                    chk("ar_snoop", 64'(ar_snoop_o), 64'(ars));
                    chk("ar_domain", 64'(ar_domain_o), 64'(dom));
                end
                k++;
                @(posedge clk); #1;
            end
            ar_ready_i = 1'b0;
            k = 0; got = 0;
            while (!got) begin
                r_valid_i = (k >= r_dly);
                r_data_i  = r_valid_i ? rd : {$urandom, $urandom};
                r_resp_i  = {2'b00, rresp};
                @(negedge clk); #1;
                chk("r_ready", 64'(r_ready_o), 64'd1);
                got = r_valid_i;
                k++;
                @(posedge clk); #1;
            end
            r_valid_i = 1'b0;
            r_resp_i  = '0;
        end else begin
            k = 0; aw_acc = 0; w_acc = 0;
            while (!(aw_acc && w_acc)) begin
                aw_ready_i = !aw_acc && (k >= aw_dly);
                w_ready_i  = !w_acc && (k >= w_dly);
                @(negedge clk); #1;
                chk("aw_valid_level", 64'(aw_valid_o), 64'(!aw_acc));
                chk("w_valid_level", 64'(w_valid_o), 64'(!w_acc));
                if (aw_ready_i) begin
                    aw_acc = 1;
                    chk("aw_addr", aw_addr_o, r.addr);
                    chk("aw_size", 64'(aw_size_o), 64'({1'b0, r.size}));
                    chk("aw_id", 64'(aw_id_o), 64'(r.id));
                    chk("aw_snoop", 64'(aw_snoop_o), 64'(aws));
                    chk("aw_domain", 64'(aw_domain_o), 64'(dom));
                end
                if (w_ready_i) begin
                    w_acc = 1;
                    chk("w_data", w_data_o, r.wdata);
                    chk("w_strb", 64'(w_strb_o), 64'(r.be));
                    chk("w_last", 64'(w_last_o), 64'd1);
                end
                k++;
                @(posedge clk); #1;
            end
            aw_ready_i = 1'b0;
            w_ready_i  = 1'b0;
            k = 0; got = 0;
            while (!got) begin
                b_valid_i = (k >= b_dly);
                b_resp_i  = bresp;
                @(negedge clk); #1;
                chk("b_ready", 64'(b_ready_o), 64'd1);
                got = b_valid_i;
                k++;
                @(posedge clk); #1;
            end
            b_valid_i = 1'b0;
            b_resp_i  = '0;
        end
        if (r.amo == AMO_NONE) begin
            @(negedge clk); #1;
        end
        chk("valid_cycle", 64'(rsp_o.valid), 64'd1);
        resp_cyc = cyc;
    endtask

    function automatic bypass_req_t rand_req();
        bypass_req_t r;
        r         = '0;
        r.req     = 1'b1;
        r.reqtype = 2'($urandom);
        r.acetype = ace_trs_t'(4'($urandom_range(0, 7)));
        r.we      = 1'($urandom);
        r.amo     = ($urandom_range(0, 5) == 0) ? AMO_ADD : AMO_NONE;
        r.id      = 4'($urandom);
        r.addr    = {$urandom, $urandom};
        r.wdata   = {$urandom, $urandom};
        r.be      = 8'($urandom);
        r.size    = 2'($urandom);
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bypass_req_t r, r2, none;
        int          g1;
        none = '0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(rsp_o.gnt), 64'd0);
        chk("rst_valid", 64'(rsp_o.valid), 64'd0);
        chk("rst_rdata", rsp_o.rdata, 64'd0);
        chk("rst_chan_valids", 64'({ar_valid_o, r_ready_o, aw_valid_o, w_valid_o, b_ready_o}), 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Directed READ_SHARED at minimum latency.
        r = '0; r.req = 1'b1; r.acetype = READ_SHARED; r.addr = 64'h0000_0000_8000_0040;
        r.size = 2'd3; r.id = 4'd2; r.we = 1'b0; r.amo = AMO_NONE;
        do_txn(r, none, 0, 64'hDEAD_BEEF_0123_4567, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("rd_ar_latency", 64'(ar_cyc - gnt_cyc), 64'd1);
        chk("rd_valid_latency", 64'(resp_cyc - gnt_cyc), 64'd3);

        // Directed WRITE_BACK with slow AW and delayed B.
        r = '0; r.req = 1'b1; r.acetype = WRITE_BACK; r.we = 1'b1; r.wdata = 64'h55AA;
        r.be = 8'h0F; r.addr = 64'h1000; r.size = 2'd3; r.id = 4'd5; r.amo = AMO_NONE;
        do_txn(r, none, 0, 64'd0, 2'b00, 2'b00, 0, 0, 3, 0, 2);

        // AMO: immediate response, no bus traffic.
        r = rand_req(); r.amo = AMO_ADD;
        do_txn(r, none, 0, 64'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        chk("amo_valid_latency", 64'(resp_cyc - gnt_cyc), 64'd1);

        // Read returning SLVERR.
        r = rand_req(); r.we = 1'b0; r.amo = AMO_NONE; r.acetype = READ_ONCE;
        do_txn(r, none, 0, 64'h0123_4567_89AB_CDEF, 2'b10, 2'b00, 1, 1, 0, 0, 0);

        // Back-to-back: second request held on req throughout the first.
        r  = rand_req(); r.amo = AMO_NONE; r.we = 1'b0;
        r2 = rand_req(); r2.amo = AMO_NONE; r2.we = 1'b1;
        do_txn(r, r2, 1, {$urandom, $urandom}, 2'b00, 2'b00, 2, 1, 0, 0, 0);
        g1 = resp_cyc;
        do_txn(r2, none, 0, 64'd0, 2'b00, 2'b01, 0, 0, 1, 2, 1);
        chk("b2b_regrant", 64'(gnt_cyc - g1), 64'd1);

        for (int i = 0; i < 40; i++) begin
            r = rand_req();
            do_txn(r, none, 0, {$urandom, $urandom}, 2'($urandom), 2'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset in IDLE with req held high.
        @(posedge clk); #1;
        req_i = rand_req();
        rst_ni = 1'b0;
        @(negedge clk); #1;
        chk("rst_gnt_req_high_0", 64'(rsp_o.gnt), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("rst_gnt_req_high_1", 64'(rsp_o.gnt), 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        req_i  = '0;
        @(negedge clk); #1;
        chk("post_rst_rsp", 64'({rsp_o.gnt, rsp_o.valid, err_o}), 64'd0);
        chk("post_rst_rdata", rsp_o.rdata, 64'd0);
        chk("post_rst_chan", 64'({ar_valid_o, r_ready_o, aw_valid_o, w_valid_o, b_ready_o}), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/std_bypass_responder.md
Name: std_bypass_responder

Overview:
- Serves the dcache bypass port.
- Accepts one `bypass_req_t` request at a time, issues a single-beat ACE read or write on flattened AR/R/AW/W/B channels, and returns `bypass_rsp_t` (gnt/valid/rdata).
- Sits between the bypass arbiter of the std cache subsystem and the ACE adapter. It is the responder end of the bypass_req/bypass_rsp interface.

Parameters:
- AddrWidth, 64, width of ar_addr_o/aw_addr_o.
- DataWidth, 64, data width; single beat only.
- IdWidth, 4, AXI ID width; lower 4 bits come from req.id, upper bits are zero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- bypass_req_i  in  bypass_req_t  request from the cache (req, reqtype, acetype, amo, id, addr, wdata, we, be, size)
- bypass_rsp_o  out  bypass_rsp_t  gnt, valid, rdata
- ar_valid_o / ar_ready_i  out/in  1  read address handshake
- ar_addr_o  out  AddrWidth  read address
- ar_size_o  out  3  read size
- ar_id_o  out  IdWidth  read ID
- ar_snoop_o  out  4  ARSNOOP
- ar_domain_o  out  2  ARDOMAIN
- r_valid_i / r_ready_o  in/out  1  read data handshake
- r_data_i  in  DataWidth  read data
- r_resp_i  in  4  RRESP (ACE)
- aw_valid_o / aw_ready_i  out/in  1  write address handshake
- aw_addr_o  out  AddrWidth  write address
- aw_size_o  out  3  write size
- aw_id_o  out  IdWidth  write ID
- aw_snoop_o  out  3  AWSNOOP
- aw_domain_o  out  2  AWDOMAIN
- w_valid_o / w_ready_i  out/in  1  write data handshake
- w_data_o  out  DataWidth  write data
- w_strb_o  out  DataWidth/8  write strobes
- w_last_o  out  1  tied to 1
- b_valid_i / b_ready_o  in/out  1  write response handshake
- b_resp_i  in  2  BRESP
- err_o  out  1  one-cycle error pulse (optional feature only; 0 otherwise)

Behaviour:
- Reset: state IDLE, request register cleared. All valid/ready outputs and gnt/valid are 0; rdata is 0.
- gnt = req && state==IDLE (combinational).
- On gnt, the request is latched. Next state is RD_ADDR if !we, otherwise WR_ADDR_DATA.
- Only one request is outstanding at a time. A req arriving in any non-IDLE state is held off (gnt=0); the requester must keep req asserted.
- RD_ADDR:
  - ar_valid_o=1, holding the latched addr/size/id.
  - On ar_ready_i, go to RD_DATA.
- RD_DATA:
  - r_ready_o=1.
  - On r_valid_i, capture r_data_i into rdata and go to RESP.
- WR_ADDR_DATA:
  - aw_valid_o and w_valid_o assert together; each drops independently after its own handshake (aw_done/w_done flags).
  - Both may complete in the same cycle.
  - When both are done, go to WR_RESP.
  - w_strb_o = be; w_data_o = wdata.
- WR_RESP:
  - b_ready_o=1.
  - On b_valid_i, go to RESP.
- RESP:
  - valid=1 for exactly one cycle, then IDLE.
  - rdata holds the captured value (writes return 0).
  - Earliest regrant is the cycle after RESP.
- Minimum read latency: gnt at cycle 0, AR at cycle 1, R at cycle 2, valid at cycle 3.
- size maps to AxSIZE as {1'b0, size}.
- ACE encoding:
  - READ_NO_SNOOP: 0000/00.
  - READ_ONCE: 0000/01.
  - READ_SHARED: 0001/01.
  - READ_UNIQUE: 0111/01.
  - CLEAN_UNIQUE: 1011/01, issued on AR with no data expected beyond the single R beat.
  - WRITE_NO_SNOOP: 000/00.
  - WRITE_UNIQUE: 000/01.
  - WRITE_BACK: 011/00.
- An acetype inconsistent with we (read type with we=1, or the reverse) follows we and uses the NoSnoop encoding.
- amo != AMO_NONE: granted, no bus traffic, RESP next cycle with rdata='1.
- Bus handshakes are held stable until accepted; valid is never withdrawn.
- Reset mid-transaction abandons it. The bench must not issue reset with a channel handshake pending.

Optional Feature:
- Macro: STD_BYPASS_RESP_CHECK_EN.
- With the macro defined:
  - RRESP[1:0] or BRESP != OKAY/EXOKAY forces rdata='1.
  - err_o pulses in the RESP cycle.
- Without the macro: response codes are ignored, rdata comes straight from R, and err_o is tied to 0.

Decomposition:
- Add bypass_fsm_t (IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP) and function ace_snoop_enc(ace_trs_t, we) to std_cache_pkg; the function returns {arsnoop, awsnoop, domain}.
- bypass_req_t/bypass_rsp_t/ace_trs_t are reused from std_cache_pkg.
- No sub-module; single flat FSM.

Test Plan:
- READ_SHARED, addr=0x8000_0040, size=3, id=2, ready=1 everywhere, r_data=0xDEAD_BEEF_0123_4567:
  - gnt at cycle 0; ar_snoop=0001, domain=01, ar_id=2 at cycle 1.
  - valid with that rdata at cycle 3.
- WRITE_BACK, wdata=0x55AA, be=0x0F:
  - aw_ready delayed 3 cycles, w_ready immediate: w drops after 1 cycle, aw after 3.
  - b_valid 2 cycles later produces valid with rdata=0; aw_snoop=011.
- Back-to-back requests held on req: second gnt arrives exactly 1 cycle after the first valid; gnt is never asserted while busy.
- amo=AMO_ADD: gnt, then valid with rdata=all-ones the next cycle; no ar/aw valid at any point.
- With STD_BYPASS_RESP_CHECK_EN, read with r_resp=SLVERR: rdata=all-ones and err_o=1 in the valid cycle. Without the macro: rdata=r_data and err_o=0.
- Reset asserted in IDLE with req=1: gnt=0 during reset, and all outputs are 0 the cycle after reset.
